// File: rtl/path_cap_pkg.sv
// ---------------------------------------------------------------------------
// path_cap_pkg
// Shared definitions for the path-planner mailbox responder.
//   - Default mailbox base address, node width and FIFO depth
//   - Mailbox register offsets (OFF_START, OFF_END, OFF_NODE, OFF_DONE)
//   - Job state enumeration
// ---------------------------------------------------------------------------
package path_cap_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0200_0000;
    localparam int          DEF_NODE_W    = 5;
    localparam int          DEF_DEPTH     = 32;

    localparam logic [31:0] OFF_START = 32'h0;
    localparam logic [31:0] OFF_END   = 32'h4;
    localparam logic [31:0] OFF_NODE  = 32'h8;
    localparam logic [31:0] OFF_DONE  = 32'hC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/path_fifo.sv
// ---------------------------------------------------------------------------
// path_fifo
// Synchronous FIFO holding the captured path nodes. A push into a full FIFO
// is accepted when a pop happens in the same cycle. Flush empties the FIFO
// and takes priority over push/pop.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_flush          discard all contents
//   i_push, i_data   write request and data
//   i_pop            read request (ignored when empty)
//   o_data           head entry, 0 while empty
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries
// ---------------------------------------------------------------------------
module path_fifo
    import path_cap_pkg::*;
#(
    parameter int W     = DEF_NODE_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  w_count;
    logic         w_do_push;
    logic         w_do_pop;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (w_count == '0);
    assign o_full    = (w_count == (AW+1)'(DEPTH));
    assign o_count   = w_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the empty mask on o_data hides stale contents.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/path_capture_mmio.sv
// ---------------------------------------------------------------------------
// path_capture_mmio
// Mailbox responder on the CPU data bus for the path-planner program.
// Supplies START/END points, captures NODE_POINT stores into a FIFO,
// detects the CPU_DONE store and streams nodes to the navigation controller.
// The CPU is held in reset whenever no job is running.
// Optional feature macro: PATH_CAP_RANGE_CHECK_EN (reject out-of-range nodes
// and flag bad_node; otherwise nodes are truncated and bad_node is 0).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start_point, end_point       job endpoints, latched on load_points rise
//   load_points                  rising edge starts a new job
//   MemWrite, DataAdr, WriteData CPU store bus
//   ReadData                     combinational mailbox read data
//   cpu_run                      1 = CPU released from reset
//   node_valid/node_data/node_ready  node stream to the consumer
//   node_count                   accepted node pushes in this job
//   path_done                    job finished and FIFO drained
//   overflow, bad_node           sticky error flags
// ---------------------------------------------------------------------------
module path_capture_mmio
    import path_cap_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          NODE_W    = DEF_NODE_W,
    parameter int          DEPTH     = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NODE_W-1:0]      start_point,
    input  logic [NODE_W-1:0]      end_point,
    input  logic                   load_points,
    input  logic                   MemWrite,
    input  logic [31:0]            DataAdr,
    input  logic [31:0]            WriteData,
    output logic [31:0]            ReadData,
    output logic                   cpu_run,
    output logic                   node_valid,
    output logic [NODE_W-1:0]      node_data,
    input  logic                   node_ready,
    output logic [$clog2(DEPTH):0] node_count,
    output logic                   path_done,
    output logic                   overflow,
    output logic                   bad_node
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t            r_state;
    logic              r_load_d;
    logic              r_pending;
    logic [NODE_W-1:0] r_start_pt;
    logic [NODE_W-1:0] r_end_pt;
    logic [NODE_W-1:0] r_last_node;
    logic [CW-1:0]     r_node_count;
    logic              r_overflow;

    logic              w_load_edge;
    logic              w_store;
    logic              w_node_store;
    logic              w_done_store;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_fifo_count;

    assign w_load_edge  = load_points && !r_load_d;
    // Stores only count while a job runs; a load edge in the same cycle wins.
    assign w_store      = MemWrite && (r_state == ST_RUN) && !w_load_edge;
    assign w_node_store = w_store && (DataAdr == BASE_ADDR + OFF_NODE);
    assign w_done_store = w_store && (DataAdr == BASE_ADDR + OFF_DONE) && (WriteData != '0);

`ifdef PATH_CAP_RANGE_CHECK_EN
    logic r_bad_node;
    logic w_in_range;
    assign w_in_range = ((WriteData >> NODE_W) == '0);
    assign w_push_req = w_node_store && w_in_range;
    assign bad_node   = r_bad_node;
`else
    assign w_push_req = w_node_store;
    assign bad_node   = 1'b0;
`endif

    assign node_valid = !w_empty && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_pop      = node_valid && node_ready;
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    assign cpu_run    = (r_state == ST_RUN);
    assign path_done  = (r_state == ST_DONE);
    assign node_count = r_node_count;
    assign overflow   = r_overflow;

    path_fifo #(
        .W     (NODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_flush (w_load_edge),
        .i_push  (w_push_ok),
        .i_data  (WriteData[NODE_W-1:0]),
        .i_pop   (w_pop),
        .o_data  (node_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    // Job FSM and capture registers. A load edge parks the FSM in IDLE for
    // one cycle (CPU held in reset while the FIFO flushes), then r_pending
    // moves it into RUN. DRAIN finishes at the edge of the final pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_load_d     <= 1'b0;
            r_pending    <= 1'b0;
            r_start_pt   <= '0;
            r_end_pt     <= '0;
            r_last_node  <= '0;
            r_node_count <= '0;
            r_overflow   <= 1'b0;
`ifdef PATH_CAP_RANGE_CHECK_EN
            r_bad_node   <= 1'b0;
`endif
        end else begin
            r_load_d <= load_points;
            if (w_load_edge) begin
                r_state      <= ST_IDLE;
                r_pending    <= 1'b1;
                r_start_pt   <= start_point;
                r_end_pt     <= end_point;
                r_last_node  <= '0;
                r_node_count <= '0;
                r_overflow   <= 1'b0;
`ifdef PATH_CAP_RANGE_CHECK_EN
                r_bad_node   <= 1'b0;
`endif
            end else begin
                r_pending <= 1'b0;
                case (r_state)
                    ST_IDLE:  if (r_pending) r_state <= ST_RUN;
                    ST_RUN:   if (w_done_store) r_state <= ST_DRAIN;
                    ST_DRAIN: if (w_empty || (w_pop && w_fifo_count == CW'(1)))
                                  r_state <= ST_DONE;
                    default:  r_state <= r_state;
                endcase
                if (w_push_ok) begin
                    r_node_count <= r_node_count + CW'(1);
                    r_last_node  <= WriteData[NODE_W-1:0];
                end
                if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
`ifdef PATH_CAP_RANGE_CHECK_EN
                if (w_node_store && !w_in_range) r_bad_node <= 1'b1;
`endif
            end
        end
    end

    // Mailbox read decode; unmapped addresses return zero.
    always_comb begin
        ReadData = '0;
        if (DataAdr == BASE_ADDR + OFF_START)
            ReadData = {{(32-NODE_W){1'b0}}, r_start_pt};
        else if (DataAdr == BASE_ADDR + OFF_END)
            ReadData = {{(32-NODE_W){1'b0}}, r_end_pt};
        else if (DataAdr == BASE_ADDR + OFF_NODE)
            ReadData = {{(32-NODE_W){1'b0}}, r_last_node};
        else if (DataAdr == BASE_ADDR + OFF_DONE)
            ReadData = {31'b0, (r_state == ST_DRAIN) || (r_state == ST_DONE)};
    end

endmodule

// File: doc/path_capture_mmio.md
# path_capture_mmio

Memory-mapped responder on the RISC-V CPU data bus that serves the path-planner program's mailbox at BASE_ADDR. It supplies START_POINT/END_POINT to the CPU, captures each NODE_POINT store into a path FIFO, and detects the CPU_DONE store. It then streams the captured node sequence to the navigation controller over a valid/ready port and holds the CPU in reset whenever no job is active.

## Interface
- BASE_ADDR, 32'h02000000, mailbox base address; offsets +0x0 START_POINT, +0x4 END_POINT, +0x8 NODE_POINT, +0xC CPU_DONE
- NODE_W, 5, node index width
- DEPTH, 32, path FIFO entries (power of two)
- clk  in  1  system clock (50 MHz domain); all logic is on posedge
- reset_n  in  1  asynchronous, active-low reset
- start_point  in  NODE_W  job start node; latched on load_points
- end_point  in  NODE_W  job end node; latched on load_points
- load_points  in  1  level signal; a rising edge starts a new job
- MemWrite  in  1  CPU store strobe
- DataAdr  in  32  CPU data address
- WriteData  in  32  CPU store data
- ReadData  out  32  mailbox read data (combinational)
- cpu_run  out  1  1 = CPU out of reset; 0 = CPU held in reset
- node_valid  out  1  node_data valid
- node_data  out  NODE_W  FIFO head node
- node_ready  in  1  consumer accepts node
- node_count  out  $clog2(DEPTH)+1  nodes captured in the current job
- path_done  out  1  job complete and FIFO drained
- overflow  out  1  sticky; a NODE_POINT was dropped because the FIFO was full
- bad_node  out  1  sticky range error (see Configuration)

## Operation
- States: IDLE -> RUN -> DRAIN -> DONE. Any load_points rising edge (edge detected from a registered copy) goes to RUN from any state.
- On load_points edge: latch start_point/end_point, flush FIFO, clear node_count, overflow, bad_node and path_done. cpu_run=0 in that cycle; RUN is entered next cycle.
- RUN: cpu_run=1. A store to +0x8 pushes WriteData[NODE_W-1:0] and increments node_count. A store to +0xC with WriteData!=0 goes to DRAIN. A store to +0xC with value 0 is ignored.
- DRAIN: cpu_run=0. Goes to DONE on the first cycle the FIFO is empty.
- DONE: path_done=1 until the next load_points edge.
- Stores in IDLE/DRAIN/DONE, stores to +0x0/+0x4, and stores to unmapped addresses are ignored.
- ReadData: +0x0 {0,start}, +0x4 {0,end}, +0x8 {0,last pushed node} (0 if none), +0xC {31'b0, state==DRAIN||DONE}, any other address 0.
- node_valid = FIFO non-empty in RUN or DRAIN, so streaming may overlap capture. A pop occurs on node_valid&&node_ready.
- Full FIFO: a push is dropped and overflow is set, unless a pop happens in the same cycle, in which case the push is accepted. node_count counts accepted pushes only.

## Timing
- Reset values: state IDLE, cpu_run 0, ReadData follows address with latches at 0, node_valid 0, node_data 0, node_count 0, path_done 0, overflow 0, bad_node 0.
- Store at posedge N: node_valid is visible after posedge N (one-cycle latency). node_count updates at the same edge.
- CPU_DONE store at edge N: cpu_run=0 after N. path_done=1 after the edge at which the last pop occurs.
- load_points edge mid-RUN aborts the job. The FIFO contents are lost, and cpu_run drops for at least one cycle.
- Async reset mid-job returns to IDLE immediately; there is no partial output.

## Configuration
- PATH_CAP_RANGE_CHECK_EN defined: a NODE_POINT store with WriteData >= 2**NODE_W is not pushed and sets bad_node.
- Not defined: the value is truncated to NODE_W bits and pushed; bad_node is tied to 0.

## Structure
- Package path_cap_pkg holds:
  - mailbox offset localparams (OFF_START, OFF_END, OFF_NODE, OFF_DONE)
  - state enum typedef
  - NODE_W default
- Sub-module path_fifo: synchronous FIFO with push/pop/full/empty, simultaneous push+pop allowed when full. The top holds the FSM, address decode and sticky flags.

## Test plan
- Reset, then load_points with start=8, end=17 -> cpu_run=1 one cycle later; reads of +0x0/+0x4 return 8/17.
- Stores of 8,9,13,17 to +0x8 with node_ready=1, then 1 to +0xC -> node_data sequence 8,9,13,17, node_count=4, cpu_run=0, then path_done=1.
- node_ready=0 with 33 node stores -> node_count=32, overflow=1. Releasing ready drains exactly 32 nodes, the first 32 stored.
- Full FIFO with ready=1 and a push in the same cycle -> push accepted, overflow stays 0.
- With the macro, a store of 40 to +0x8 -> bad_node=1, no push. Without the macro -> node 8 pushed.
- load_points edge during RUN after 3 nodes -> FIFO empty, node_count=0, a new job runs; reset_n low mid-DRAIN -> IDLE, all outputs at reset values.
